// File: rtl/prbs_checker.sv
// prbs_checker: self-synchronising Fibonacci PRBS checker with lock tracking and a
// saturating error counter. Define PRBS_CHK_BITCNT_EN to add the bit_count output.
module prbs_checker #(
  parameter int unsigned POLY_W     = 7,
  parameter int unsigned TAP_A      = 7,
  parameter int unsigned TAP_B      = 6,
  parameter int unsigned LOCK_CNT   = 16,
  parameter int unsigned UNLOCK_ERR = 4,
  parameter int unsigned ERR_W      = 16
`ifdef PRBS_CHK_BITCNT_EN
  ,
  parameter int unsigned BCNT_W     = 32
`endif
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              en,
  input  logic              din,
  input  logic              din_valid,
  input  logic              clear,
  output logic              locked,
  output logic              err_pulse,
  output logic [ERR_W-1:0]  err_count
`ifdef PRBS_CHK_BITCNT_EN
  ,
  output logic [BCNT_W-1:0] bit_count
`endif
);

  localparam int unsigned FILL_W  = $clog2(POLY_W + 1);
  localparam int unsigned MATCH_W = $clog2(LOCK_CNT + 1);
  localparam int unsigned BAD_W   = $clog2(UNLOCK_ERR + 1);

  localparam logic [FILL_W-1:0]  FILL_DONE  = FILL_W'(POLY_W);
  localparam logic [MATCH_W-1:0] LOCK_LIM   = MATCH_W'(LOCK_CNT);
  localparam logic [BAD_W-1:0]   UNLOCK_LIM = BAD_W'(UNLOCK_ERR);

  typedef enum logic [1:0] {
    ST_FILL    = 2'd0,
    ST_ACQUIRE = 2'd1,
    ST_LOCKED  = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [POLY_W-1:0]  lfsr_q, lfsr_d;
  logic [FILL_W-1:0]  fill_q, fill_d;
  logic [MATCH_W-1:0] match_q, match_d;
  logic [MATCH_W-1:0] clean_q, clean_d;
  logic [BAD_W-1:0]   bad_q, bad_d;
  logic               locked_q, locked_d;
  logic               err_pulse_q, err_pulse_d;
  logic [ERR_W-1:0]   err_count_q, err_count_d;
  logic               predict;
  logic               err_hit;

  assign predict = lfsr_q[TAP_A-1] ^ lfsr_q[TAP_B-1];

  always_comb begin
    state_d     = state_q;
    lfsr_d      = lfsr_q;
    fill_d      = fill_q;
    match_d     = match_q;
    clean_d     = clean_q;
    bad_d       = bad_q;
    locked_d    = locked_q;
    err_pulse_d = 1'b0;
    err_hit     = 1'b0;
    err_count_d = clear ? '0 : err_count_q;

    if (!en) begin
      state_d  = ST_FILL;
      fill_d   = '0;
      match_d  = '0;
      clean_d  = '0;
      bad_d    = '0;
      locked_d = 1'b0;
    end else if (din_valid) begin
      unique case (state_q)
        ST_FILL: begin
          lfsr_d = {lfsr_q[POLY_W-2:0], din};
          fill_d = fill_q + FILL_W'(1);
          if (fill_d == FILL_DONE) begin
            state_d = ST_ACQUIRE;
            match_d = '0;
          end
        end
        ST_ACQUIRE: begin
          lfsr_d = {lfsr_q[POLY_W-2:0], din};
          // an all-zero register predicts zeros forever, so it must never count as a match
          if ((din == predict) && (|lfsr_q)) begin
            match_d = match_q + MATCH_W'(1);
          end else begin
            match_d = '0;
          end
          if (match_d == LOCK_LIM) begin
            state_d  = ST_LOCKED;
            locked_d = 1'b1;
            bad_d    = '0;
            clean_d  = '0;
          end
        end
        ST_LOCKED: begin
          lfsr_d = {lfsr_q[POLY_W-2:0], predict};
          if (din != predict) begin
            err_hit     = 1'b1;
            err_pulse_d = 1'b1;
            clean_d     = '0;
            bad_d       = bad_q + BAD_W'(1);
            if (bad_d == UNLOCK_LIM) begin
              state_d  = ST_FILL;
              locked_d = 1'b0;
              fill_d   = '0;
              match_d  = '0;
            end
          end else begin
            clean_d = clean_q + MATCH_W'(1);
            if (clean_d == LOCK_LIM) begin
              bad_d   = '0;
              clean_d = '0;
            end
          end
        end
        default: begin
          state_d  = ST_FILL;
          fill_d   = '0;
          locked_d = 1'b0;
        end
      endcase
    end

    // clear is applied first so an error in the same cycle lands on a zeroed count
    if (err_hit && (err_count_d != '1)) begin
      err_count_d = err_count_d + ERR_W'(1);
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= ST_FILL;
      lfsr_q      <= '0;
      fill_q      <= '0;
      match_q     <= '0;
      clean_q     <= '0;
      bad_q       <= '0;
      locked_q    <= 1'b0;
      err_pulse_q <= 1'b0;
      err_count_q <= '0;
    end else begin
      state_q     <= state_d;
      lfsr_q      <= lfsr_d;
      fill_q      <= fill_d;
      match_q     <= match_d;
      clean_q     <= clean_d;
      bad_q       <= bad_d;
      locked_q    <= locked_d;
      err_pulse_q <= err_pulse_d;
      err_count_q <= err_count_d;
    end
  end

  assign locked    = locked_q;
  assign err_pulse = err_pulse_q;
  assign err_count = err_count_q;

`ifdef PRBS_CHK_BITCNT_EN
  logic [BCNT_W-1:0] bit_count_q, bit_count_d;

  always_comb begin
    bit_count_d = clear ? '0 : bit_count_q;
    if (en && din_valid && (state_q == ST_LOCKED) && (bit_count_d != '1)) begin
      bit_count_d = bit_count_d + BCNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      bit_count_q <= '0;
    end else begin
      bit_count_q <= bit_count_d;
    end
  end

  assign bit_count = bit_count_q;
`endif

endmodule

// File: tb/tb_prbs_checker.sv
// Self-checking bench for prbs_checker: directed scenarios plus a randomized run,
// both judged against a sequence-level reference model of the checker.
module tb_prbs_checker;

  logic        clk = 1'b0;
  logic        resetn, en, din, din_valid, clear;
  logic        locked, err_pulse;
  logic [15:0] err_count;
  logic        locked4, err_pulse4;
  logic [3:0]  err_count4;
`ifdef PRBS_CHK_BITCNT_EN
  logic [31:0] bit_count, bit_count4;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  prbs_checker dut (
    .clk(clk), .resetn(resetn), .en(en), .din(din), .din_valid(din_valid), .clear(clear),
    .locked(locked), .err_pulse(err_pulse), .err_count(err_count)
`ifdef PRBS_CHK_BITCNT_EN
    , .bit_count(bit_count)
`endif
  );

  prbs_checker #(.ERR_W(4)) dut4 (
    .clk(clk), .resetn(resetn), .en(en), .din(din), .din_valid(din_valid), .clear(clear),
    .locked(locked4), .err_pulse(err_pulse4), .err_count(err_count4)
`ifdef PRBS_CHK_BITCNT_EN
    , .bit_count(bit_count4)
`endif
  );

  // Stimulus source: x^7+x^6+1 sequence, s[n] = s[n-7] ^ s[n-6]
  logic [6:0] gen_state;
  task automatic gen_bit(output logic b);
    b = gen_state[6] ^ gen_state[5];
    gen_state = {gen_state[5:0], b};
  endtask

  // Reference model: the last seven sequence bits (oldest first) and the checker's phase
  localparam int M_FILL = 0;
  localparam int M_ACQ  = 1;
  localparam int M_LOCK = 2;
  bit     m_hist[$];
  int     m_mode, m_fill, m_match, m_bad, m_clean, m_err_raw;
  longint m_bits;
  logic   exp_locked, exp_pulse;

  function automatic logic [15:0] exp_cnt16();
    return (m_err_raw > 65535) ? 16'hFFFF : 16'(m_err_raw);
  endfunction
  function automatic logic [3:0] exp_cnt4();
    return (m_err_raw > 15) ? 4'hF : 4'(m_err_raw);
  endfunction

  task automatic model_reset();
    m_hist = {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    m_mode = M_FILL; m_fill = 0; m_match = 0; m_bad = 0; m_clean = 0;
    m_err_raw = 0; m_bits = 0; exp_locked = 1'b0; exp_pulse = 1'b0;
  endtask

  task automatic model_step(input logic e, input logic v, input logic d, input logic c);
    logic p, nz;
    exp_pulse = 1'b0;
    if (c) begin m_err_raw = 0; m_bits = 0; end
    if (!e) begin
      m_mode = M_FILL; m_fill = 0; m_match = 0; m_bad = 0; m_clean = 0; exp_locked = 1'b0;
    end else if (v) begin
      p  = m_hist[0] ^ m_hist[1];
      nz = 1'b0;
      foreach (m_hist[i]) nz = nz | m_hist[i];
      void'(m_hist.pop_front());
      case (m_mode)
        M_FILL: begin
          m_hist.push_back(d);
          m_fill++;
          if (m_fill == 7) begin m_mode = M_ACQ; m_match = 0; end
        end
        M_ACQ: begin
          m_hist.push_back(d);
          if (d == p && nz) m_match++; else m_match = 0;
          if (m_match == 16) begin
            m_mode = M_LOCK; exp_locked = 1'b1; m_bad = 0; m_clean = 0;
          end
        end
        default: begin
          m_hist.push_back(p);
          m_bits++;
          if (d != p) begin
            exp_pulse = 1'b1; m_err_raw++; m_bad++; m_clean = 0;
            if (m_bad == 4) begin
              m_mode = M_FILL; exp_locked = 1'b0; m_fill = 0; m_match = 0;
            end
          end else begin
            m_clean++;
            if (m_clean == 16) begin m_bad = 0; m_clean = 0; end
          end
        end
      endcase
    end
  endtask

  task automatic drive(input logic e, input logic v, input logic d, input logic c);
    en = e; din_valid = v; din = d; clear = c;
    @(posedge clk);
    model_step(e, v, d, c);
    #1;
  endtask

  task automatic do_reset();
    resetn = 1'b0; en = 1'b0; din = 1'b0; din_valid = 1'b0; clear = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    resetn = 1'b1;
    model_reset();
  endtask

  task automatic test_reset();
    do_reset();
    n_tests++;
    if (locked !== 1'b0 || err_pulse !== 1'b0 || err_count !== 16'h0) begin
      n_fail++;
      $display("FAIL reset_values: locked=%b pulse=%b count=%0d, required 0/0/0", locked, err_pulse, err_count);
    end
    for (int i = 0; i < 20; i++) begin
      drive(1'b1, 1'b0, 1'($urandom_range(1)), 1'b0);
      n_tests++;
      if (locked !== 1'b0 || err_pulse !== 1'b0 || err_count !== 16'h0 || err_count4 !== 4'h0) begin
        n_fail++;
        $display("FAIL idle_no_valid cyc %0d: locked=%b pulse=%b count=%0d, required 0/0/0", i, locked, err_pulse, err_count);
      end
    end
  endtask

  task automatic test_clean_lock();
    logic b;
    gen_state = 7'h7F;
    for (int n = 1; n <= 500; n++) begin
      gen_bit(b);
      drive(1'b1, 1'b1, b, 1'b0);
      n_tests++;
      if (locked !== (n >= 23) || locked !== exp_locked) begin
        n_fail++;
        $display("FAIL clean_lock bit %0d: locked=%b required %b", n, locked, (n >= 23));
      end
      n_tests++;
      if (err_count !== 16'h0 || err_pulse !== 1'b0) begin
        n_fail++;
        $display("FAIL clean_no_err bit %0d: count=%0d pulse=%b required 0/0", n, err_count, err_pulse);
      end
    end
  endtask

  task automatic test_single_error();
    logic b;
    logic [15:0] held;
    int pulses = 0;
    for (int n = 1; n <= 150; n++) begin
      gen_bit(b);
      drive(1'b1, 1'b1, b ^ (n == 100), 1'b0);
      if (err_pulse === 1'b1) pulses++;
      n_tests++;
      if (err_pulse !== (n == 100) || locked !== 1'b1 || err_count !== ((n >= 100) ? 16'd1 : 16'd0)) begin
        n_fail++;
        $display("FAIL single_err bit %0d: pulse=%b locked=%b count=%0d required %b/1/%0d",
                 n, err_pulse, locked, err_count, (n == 100), (n >= 100) ? 1 : 0);
      end
      if (n % 10 == 0) begin
        held = err_count;
        for (int g = 0; g < 3; g++) begin
          drive(1'b1, 1'b0, 1'($urandom_range(1)), 1'b0);
          n_tests++;
          if (err_pulse !== 1'b0 || locked !== 1'b1 || err_count !== held) begin
            n_fail++;
            $display("FAIL valid_gap bit %0d: pulse=%b locked=%b count=%0d required 0/1/%0d", n, err_pulse, locked, err_count, held);
          end
        end
      end
    end
    n_tests++;
    if (pulses != 1) begin
      n_fail++;
      $display("FAIL single_err_pulses: got %0d pulses required 1", pulses);
    end
  endtask

  task automatic test_unlock_relock();
    logic b;
    gen_bit(b);
    drive(1'b1, 1'b1, b, 1'b1);
    n_tests++;
    if (err_count !== 16'h0 || locked !== 1'b1) begin
      n_fail++;
      $display("FAIL clear_clean: count=%0d locked=%b required 0/1", err_count, locked);
    end
    for (int k = 0; k < 16; k++) begin
      gen_bit(b);
      drive(1'b1, 1'b1, b ^ (k % 5 == 0), 1'b0);
      n_tests++;
      if (locked !== (k < 15) || err_count !== 16'(k / 5 + 1)) begin
        n_fail++;
        $display("FAIL unlock k %0d: locked=%b count=%0d required %b/%0d", k, locked, err_count, (k < 15), k / 5 + 1);
      end
    end
    for (int n = 1; n <= 30; n++) begin
      gen_bit(b);
      drive(1'b1, 1'b1, b, 1'b0);
      n_tests++;
      if (locked !== (n >= 23) || err_count !== 16'd4) begin
        n_fail++;
        $display("FAIL relock bit %0d: locked=%b count=%0d required %b/4", n, locked, err_count, (n >= 23));
      end
    end
  endtask

  task automatic test_constant_stream();
    logic [15:0] held;
    for (int v = 0; v < 2; v++) begin
      held = err_count;
      drive(1'b0, 1'b0, 1'b0, 1'b0);
      n_tests++;
      if (locked !== 1'b0 || err_count !== held) begin
        n_fail++;
        $display("FAIL enable_low: locked=%b count=%0d required 0/%0d", locked, err_count, held);
      end
      for (int n = 0; n < 200; n++) begin
        drive(1'b1, 1'b1, 1'(v), 1'b0);
        n_tests++;
        if (locked !== 1'b0 || exp_locked !== 1'b0) begin
          n_fail++;
          $display("FAIL const_%0d bit %0d: locked=%b required 0", v, n, locked);
        end
      end
    end
  endtask

  task automatic test_saturate();
    logic b;
    drive(1'b0, 1'b0, 1'b0, 1'b1);
    for (int n = 0; n < 30; n++) begin
      gen_bit(b);
      drive(1'b1, 1'b1, b, 1'b0);
    end
    for (int e = 0; e < 20; e++) begin
      for (int k = 0; k < 20; k++) begin
        gen_bit(b);
        drive(1'b1, 1'b1, b ^ (k == 0), 1'b0);
        n_tests++;
        if (err_count !== exp_cnt16() || err_count4 !== exp_cnt4() || locked !== 1'b1) begin
          n_fail++;
          $display("FAIL sat_track e %0d k %0d: c16=%0d c4=%0d locked=%b required %0d/%0d/1",
                   e, k, err_count, err_count4, locked, exp_cnt16(), exp_cnt4());
        end
      end
    end
    n_tests++;
    if (err_count4 !== 4'd15 || err_count !== 16'd20) begin
      n_fail++;
      $display("FAIL saturate: c4=%0d c16=%0d required 15/20", err_count4, err_count);
    end
    gen_bit(b);
    drive(1'b1, 1'b1, ~b, 1'b1);
    n_tests++;
    if (err_count !== 16'd1 || err_count4 !== 4'd1 || err_pulse !== 1'b1) begin
      n_fail++;
      $display("FAIL clear_with_err: c16=%0d c4=%0d pulse=%b required 1/1/1", err_count, err_count4, err_pulse);
    end
  endtask

  task automatic test_async_reset();
    logic b;
    for (int n = 0; n < 5; n++) begin
      gen_bit(b);
      drive(1'b1, 1'b1, b ^ (n == 4), 1'b0);
    end
    n_tests++;
    if (locked !== 1'b1 || err_pulse !== 1'b1) begin
      n_fail++;
      $display("FAIL pre_reset: locked=%b pulse=%b required 1/1", locked, err_pulse);
    end
    #2;
    resetn = 1'b0;
    #1;
    n_tests++;
    if (locked !== 1'b0 || err_pulse !== 1'b0 || err_count !== 16'h0 || err_count4 !== 4'h0) begin
      n_fail++;
      $display("FAIL async_reset: locked=%b pulse=%b c16=%0d c4=%0d required all 0", locked, err_pulse, err_count, err_count4);
    end
    @(posedge clk);
    #1;
    resetn = 1'b1;
    model_reset();
  endtask

  task automatic test_random();
    logic b, e, v, d, c;
    gen_state = 7'($urandom_range(1, 127));
    for (int i = 0; i < 4000; i++) begin
      e = ($urandom_range(799) != 0);
      v = ($urandom_range(9) < 7);
      c = ($urandom_range(149) == 0);
      if (v) begin
        gen_bit(b);
        d = b ^ ($urandom_range(49) == 0);
      end else begin
        d = 1'($urandom_range(1));
      end
      drive(e, v, d, c);
      n_tests++;
      if (locked !== exp_locked || err_pulse !== exp_pulse || err_count !== exp_cnt16() ||
          locked4 !== exp_locked || err_pulse4 !== exp_pulse || err_count4 !== exp_cnt4()) begin
        n_fail++;
        $display("FAIL random cyc %0d: locked=%b pulse=%b c16=%0d c4=%0d required %b/%b/%0d/%0d",
                 i, locked, err_pulse, err_count, err_count4, exp_locked, exp_pulse, exp_cnt16(), exp_cnt4());
      end
`ifdef PRBS_CHK_BITCNT_EN
      n_tests++;
      if (bit_count !== 32'(m_bits)) begin
        n_fail++;
        $display("FAIL bit_count cyc %0d: got %0d required %0d", i, bit_count, m_bits);
      end
`endif
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_clean_lock();
    test_single_error();
    test_unlock_relock();
    test_constant_stream();
    test_saturate();
    test_async_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
